gray_code_counter: RTL

//   Parametrised, registered up/down Gray-code counter: the sequential successor to the
//   4-bit combinational binary-to-Gray converter. It keeps a binary count internally and

---
 rtl/gray_code_counter_if.sv | 24 ++
 rtl/gray_code_counter.sv | 59 +++++
 2 files changed

// File: rtl/gray_code_counter_if.sv
// Command/status bundle for the registered up/down Gray-code counter.
// The master drives commands and observes the count; the counter is the slave.
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output clr, load, load_bin, en, up_dn,
    input  binary, gray, wrap
  );

  modport slave (
    input  clr, load, load_bin, en, up_dn,
    output binary, gray, wrap
  );
endinterface

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter with a registered Gray-coded copy and a wrap pulse.
// Gray is derived from the next binary value so both outputs update on the same edge.
module gray_code_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_code_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  // clr beats load beats en; only a counting step may flag a wrap.
  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (bus.clr) begin
      w_next_bin = '0;
    end else if (bus.load) begin
      w_next_bin = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        w_next_bin  = r_bin + WIDTH'(1);
        w_next_wrap = &r_bin;
      end else begin
        w_next_bin  = r_bin - WIDTH'(1);
        w_next_wrap = ~|r_bin;
      end
    end
    w_next_gray = w_next_bin ^ (w_next_bin >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= INIT_BIN;
      r_gray <= INIT_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
    end
  end

  assign bus.binary = r_bin;
  assign bus.gray   = r_gray;
  assign bus.wrap   = r_wrap;

endmodule
